// File: rtl/pulse_train_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_train_generator: emits N pulses of H cycles high, L cycles low      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pulse_train_generator #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [CNT_W-1:0] pulse_cnt,
  input  logic             abort,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  // Captured phase reloads, stored as (effective length - 1) so max length never wraps
  logic [LEN_W-1:0] high_m1_q, high_m1_d;
  logic [LEN_W-1:0] low_m1_q, low_m1_d;
  logic             pulse_q, busy_q, done_q;
  logic             accept;

  assign start_ready = (state_q == S_IDLE) & ~abort;
  assign accept      = start_valid & start_ready;
  assign pulse       = pulse_q;
  assign busy        = busy_q;
  assign done        = done_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    remain_d  = remain_q;
    high_m1_d = high_m1_q;
    low_m1_d  = low_m1_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      phase_d  = '0;
      remain_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            high_m1_d = (high_len == '0) ? '0 : high_len - LEN_ONE;
            low_m1_d  = (low_len == '0) ? '0 : low_len - LEN_ONE;
            if (pulse_cnt == '0) begin
              state_d = S_DONE;
            end else begin
              state_d  = S_HIGH;
              phase_d  = (high_len == '0) ? '0 : high_len - LEN_ONE;
              remain_d = pulse_cnt - CNT_ONE;
            end
          end
        end
        S_HIGH: begin
          if (phase_q != '0) begin
            phase_d = phase_q - LEN_ONE;
          end else if (remain_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOW;
            phase_d = low_m1_q;
          end
        end
        S_LOW: begin
          if (phase_q != '0) begin
            phase_d = phase_q - LEN_ONE;
          end else begin
            state_d  = S_HIGH;
            phase_d  = high_m1_q;
            remain_d = remain_q - CNT_ONE;
          end
        end
        default: begin
          state_d  = S_IDLE;
          phase_d  = '0;
          remain_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they stay glitch-free flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      remain_q  <= '0;
      high_m1_q <= '0;
      low_m1_q  <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      remain_q  <= remain_d;
      high_m1_q <= high_m1_d;
      low_m1_q  <= low_m1_d;
      pulse_q   <= (state_d == S_HIGH);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
- Transmit-side counterpart to the team's edge and one-cycle-pulse detectors.
- On an accepted request, drives a single-bit line with a programmable train of pulses: N pulses, each H cycles high, separated by L cycles low.
- Used as stimulus source and as a functional block wherever a downstream detector must see clean, glitch-free pulses.
- Output is registered (Moore), so the line never glitches.

Parameters:
LEN_W, 4, width of high_len / low_len fields (cycles per phase, max 2^LEN_W-1)
CNT_W, 4, width of pulse_cnt field (pulses per request, max 2^CNT_W-1)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, asynchronous, active-high
start_valid  input  1  request present
start_ready  output  1  block can accept request this cycle
high_len  input  LEN_W  cycles high per pulse; 0 treated as 1
low_len  input  LEN_W  cycles low between pulses; 0 treated as 1
pulse_cnt  input  CNT_W  number of pulses; 0 = empty request
abort  input  1  cancel current train
pulse  output  1  generated pulse line
busy  output  1  request in progress
done  output  1  one-cycle completion strobe

Behaviour:
- Reset (async, active-high): state IDLE, phase and remaining counters 0. Outputs: pulse=0, busy=0, done=0, start_ready=1 (abort=0).
- States: IDLE, HIGH, LOW, DONE.
- Outputs:
  - pulse = (state==HIGH)
  - busy = (state!=IDLE)
  - done = (state==DONE)
  - start_ready = (state==IDLE) & ~abort
- Accept occurs when start_valid & start_ready. On accept, high_len, low_len and pulse_cnt are captured. Inputs are ignored at all other times, including changes while busy.
- Effective lengths: Heff = max(high_len,1), Leff = max(low_len,1).
- Transitions:
  - IDLE + accept, pulse_cnt==0 -> DONE (no pulse).
  - IDLE + accept, pulse_cnt!=0 -> HIGH; phase=Heff-1; remaining=pulse_cnt-1.
  - HIGH, phase!=0 -> HIGH, phase-1.
  - HIGH, phase==0, remaining==0 -> DONE.
  - HIGH, phase==0, remaining!=0 -> LOW; phase=Leff-1.
  - LOW, phase!=0 -> LOW, phase-1.
  - LOW, phase==0 -> HIGH; phase=Heff-1; remaining-1.
  - DONE -> IDLE unconditionally (done high exactly 1 cycle).
- Latency:
  - First pulse high in the cycle after accept.
  - done asserts in the cycle after the last high cycle.
  - Accept cycle to done cycle = N*Heff + (N-1)*Leff + 1 cycles.
- Back-to-back requests:
  - The earliest next accept is the cycle after DONE.
  - The line is therefore low for at least 2 cycles (DONE, accept cycle) between trains.
  - This guarantees every pulse presents a rising and a falling edge to a downstream detector.
- Abort:
  - abort=1 in HIGH/LOW/DONE -> IDLE next cycle. pulse=0 from the next cycle, no done, counters cleared.
  - abort=1 in IDLE -> no effect except blocking accept that cycle.
  - abort has priority over start_valid.
- Counters never wrap. Maximum values give Heff=2^LEN_W-1 and N=2^CNT_W-1 exactly.
- Reset asserted mid-train: pulse, busy and done drop immediately (async). The block is in IDLE after reset release; a partial train is never resumed.

Test Plan:
- Reset, then accept H=1,L=1,N=3 at cycle 0 -> pulse=1 at cycles 1,3,5; 0 at 2,4; done=1 at cycle 6 only; start_ready=1 at cycle 7; busy=1 cycles 1-6.
- Accept H=3,L=2,N=2 at cycle 0 -> pulse high cycles 1-3 and 6-8, low 4-5; done at cycle 9; rising-edge count = 2, every high run exactly 3.
- Accept H=0,L=0,N=0 -> no pulse, done at cycle 1, ready at cycle 2. Separately, H=0,L=0,N=2 -> pulse at cycles 1,3 (zeros treated as 1), done at 4.
- H=4,L=1,N=2 accepted at cycle 0, abort=1 at cycle 2 -> pulse=1 cycles 1-2, pulse=0 from cycle 3, no done ever; start_ready=1 at cycle 3. abort with start_valid in IDLE -> no accept.
- Two requests back-to-back with start_valid held: H=1,N=1 twice -> pulses at cycles 1 and 4, done at 2 and 5. Accept cycle 3, low gap cycles 2-3. Changing inputs while busy does not alter the train.
- Async reset asserted mid-HIGH (between clock edges) -> pulse, busy, done go 0 without waiting for clk. After release, IDLE with start_ready=1, line stays 0 until a new accept.
